// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lif_pkg
// Description : Shared definitions for the LIF neuron array: membrane width,
//               saturation limit, the update result struct and a helper that
//               sizes channel indices.
// Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

  // Membrane width used by the update result struct. The array's W parameter
  // must equal this value because the struct carries the next membrane value.
  localparam int unsigned LIF_W = 8;

  // Saturation ceiling for a membrane value.
  localparam logic [LIF_W-1:0] V_MAX = '1;

  // Result of a single neuron update.
  typedef struct packed {
    logic [LIF_W-1:0] v_next;
    logic             spike;
  } lif_upd_t;

  // Width of a channel index; never less than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// ============================================================================
// Interface   : lif_neuron_array_if
// Description : Control, current, monitor and spike-event signals of the LIF
//               neuron array.
//   en_i          scan enable (one channel updated per enabled cycle)
//   current_i     N_CH*W packed per-channel currents, channel k at [k*W +: W]
//   thresh_i      common firing threshold, 0 disables firing
//   mon_ch_i      channel shown on nu_o
//   nu_o          registered membrane of mon_ch_i
//   spike_valid_o spike event pending
//   spike_ch_o    channel of the presented event
//   spike_ready_i consumer accepts the event
//   overflow_o    sticky dropped-event flag
//   sweep_o       pulse after the last channel has been updated
// Modports    : master (stimulus side), slave (neuron array)
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_neuron_array_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int CH_W = lif_pkg::ch_w(N_CH);

  logic              en_i;
  logic [N_CH*W-1:0] current_i;
  logic [W-1:0]      thresh_i;
  logic [CH_W-1:0]   mon_ch_i;
  logic [W-1:0]      nu_o;
  logic              spike_valid_o;
  logic [CH_W-1:0]   spike_ch_o;
  logic              spike_ready_i;
  logic              overflow_o;
  logic              sweep_o;

  modport master (
    output en_i, current_i, thresh_i, mon_ch_i, spike_ready_i,
    input  nu_o, spike_valid_o, spike_ch_o, overflow_o, sweep_o
  );

  modport slave (
    input  en_i, current_i, thresh_i, mon_ch_i, spike_ready_i,
    output nu_o, spike_valid_o, spike_ch_o, overflow_o, sweep_o
  );

endinterface
`default_nettype wire

// File: rtl/lif_neuron_core.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_core
// Description : Combinational leaky integrate-and-fire update for one neuron.
//               s = v - (v >> LEAK_SHIFT) + cur, saturated to W bits; fires
//               when thresh != 0 and the saturated value reaches thresh, in
//               which case the membrane resets to 0. A refractory neuron holds
//               0 and never fires.
// Ports       : v (membrane), cur (current), thresh (threshold),
//               refrac (refractory active) -> upd {v_next, spike}
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int W          = LIF_W,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [W-1:0] v,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] thresh,
  input  logic         refrac,
  output lif_upd_t     upd
);

  logic [W:0]   s;
  logic [W-1:0] v_sat;
  logic         fire;

  always_comb begin
    // One extra bit holds the worst case (v - leak) + cur without wrapping.
    s     = {1'b0, v} - ({1'b0, v} >> LEAK_SHIFT) + {1'b0, cur};
    v_sat = s[W] ? V_MAX : s[W-1:0];
    fire  = !refrac && (thresh != '0) && (v_sat >= thresh);

    upd        = '0;
    upd.spike  = fire;
    upd.v_next = (refrac || fire) ? '0 : v_sat;
  end

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_array
// Description : Time-multiplexed array of N_CH leaky integrate-and-fire
//               neurons sharing one update datapath. One channel is updated
//               per enabled cycle in round-robin order; spikes leave as a
//               valid/ready event stream (lowest pending channel first) and
//               the selected membrane is shown on a registered monitor.
// Ports       : clk_i  - clock, rising edge
//               reset  - synchronous reset, active high
//               bus    - lif_neuron_array_if.slave (scan control, currents,
//                        threshold, monitor, spike events, overflow, sweep)
// Config      : LIF_REFRACTORY_EN - when defined, a channel that fires sits
//               out REFRAC_SWEEPS of its own updates holding v = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int W             = LIF_W,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_SWEEPS = 2
) (
  input  logic                clk_i,
  input  logic                reset,
  lif_neuron_array_if.slave   bus
);

  localparam int              CH_W    = ch_w(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [W-1:0]    v_q [N_CH];
  logic [CH_W-1:0] ptr_q;
  logic [N_CH-1:0] pend_q;
  logic            ovf_q;
  logic            sweep_q;
  logic [W-1:0]    nu_q;

  logic [W-1:0]    cur_sel;
  lif_upd_t        upd;
  logic            refrac_act;

  logic [CH_W-1:0] evt_ch;
  logic            evt_valid;
  logic            accept;
  logic [N_CH-1:0] clr_mask;
  logic [N_CH-1:0] set_mask;
  logic [N_CH-1:0] pend_d;
  logic            drop;

  // --------------------------------------------------------------------------
  // Shared update datapath for the channel under the scan pointer
  // --------------------------------------------------------------------------
  assign cur_sel = bus.current_i[ptr_q*W +: W];

  lif_neuron_core #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_core (
    .v      (v_q[ptr_q]),
    .cur    (cur_sel),
    .thresh (bus.thresh_i),
    .refrac (refrac_act),
    .upd    (upd)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RC_W = (REFRAC_SWEEPS > 0) ? $clog2(REFRAC_SWEEPS + 1) : 1;

  logic [RC_W-1:0] rc_q [N_CH];

  assign refrac_act = (rc_q[ptr_q] != '0);

  // A firing update arms the counter; each later update of the channel
  // spends one count while the core holds the membrane at 0.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) rc_q[i] <= '0;
    end else if (bus.en_i) begin
      if (refrac_act)      rc_q[ptr_q] <= rc_q[ptr_q] - RC_W'(1);
      else if (upd.spike)  rc_q[ptr_q] <= RC_W'(REFRAC_SWEEPS);
    end
  end
`else
  assign refrac_act = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Event presentation: lowest pending channel wins
  // --------------------------------------------------------------------------
  always_comb begin
    evt_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) evt_ch = CH_W'(i);
    end
  end

  assign evt_valid = |pend_q;
  assign accept    = evt_valid & bus.spike_ready_i;

  // A new spike on the channel being accepted this edge re-arms its bit
  // without counting as a drop; otherwise a spike onto a set bit is lost.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (accept)                 clr_mask[evt_ch] = 1'b1;
    if (bus.en_i && upd.spike)  set_mask[ptr_q]  = 1'b1;
    drop   = |(set_mask & pend_q & ~clr_mask);
    pend_d = (pend_q & ~clr_mask) | set_mask;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) v_q[i] <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      sweep_q <= 1'b0;
    end else begin
      if (bus.en_i) begin
        v_q[ptr_q] <= upd.v_next;
        ptr_q      <= (ptr_q == LAST_CH) ? '0 : ptr_q + CH_W'(1);
      end
      pend_q  <= pend_d;
      if (drop) ovf_q <= 1'b1;
      sweep_q <= bus.en_i && (ptr_q == LAST_CH);
    end
  end

  // --------------------------------------------------------------------------
  // Membrane monitor (shows the value before this cycle's update)
  // --------------------------------------------------------------------------
  if ((1 << CH_W) > N_CH) begin : g_mon_range
    always_ff @(posedge clk_i) begin
      if (reset) nu_q <= '0;
      else       nu_q <= ({1'b0, bus.mon_ch_i} < (CH_W + 1)'(N_CH)) ? v_q[bus.mon_ch_i] : '0;
    end
  end else begin : g_mon_full
    // Every encodable index is a real channel.
    always_ff @(posedge clk_i) begin
      if (reset) nu_q <= '0;
      else       nu_q <= v_q[bus.mon_ch_i];
    end
  end

  assign bus.nu_o          = nu_q;
  assign bus.spike_valid_o = evt_valid;
  assign bus.spike_ch_o    = evt_ch;
  assign bus.overflow_o    = ovf_q;
  assign bus.sweep_o       = sweep_q;

endmodule
`default_nettype wire
